// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word type, fetch FSM encoding and PC constants.
package mips_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_STEP          = 32'd4;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  function automatic word_t word_align(input word_t a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset, redirect load, +4 step (wraps mod 2^32).
module pc_reg
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  word_t load_pc,
  input  logic  inc,
  output word_t pc,
  output word_t pc_plus4
);

  // Load wins over increment so a redirect never also steps the PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= word_align(RESET_PC);
    end else if (load) begin
      pc <= word_align(load_pc);
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

  assign pc_plus4 = pc + PC_STEP;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding imem request, output register plus one-entry skid.
module pc_fetch
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  word_t        NextPC,
  input  logic         Redirect,
  input  logic         Stall,
  output word_t        PCPlus4,
  output logic         ImemReq,
  output word_t        ImemAddr,
  input  logic         ImemGnt,
  input  logic         ImemValid,
  input  word_t        ImemData,
  output logic         InstrValid,
  output word_t        Instr,
  output word_t        InstrPC,
  output fetch_state_e dbg_state
);

  // Handshakes: a request transfers on a rising edge where ImemReq and ImemGnt are both high;
  // ImemValid is a one-cycle response honoured only in WAIT; an instruction transfers to decode
  // on an edge where InstrValid is high and Stall is low.

  fetch_state_e state, state_nx;
  logic  kill, kill_nx;
  logic  pc_inc, load_out, load_skid, req_fire, out_free;
  word_t pc, req_pc;
  word_t skid_instr, skid_pc;
  logic  out_valid;
  word_t out_instr, out_pc;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (Redirect),
    .load_pc  (NextPC),
    .inc      (pc_inc),
    .pc       (pc),
    .pc_plus4 (PCPlus4)
  );

  assign out_free = !out_valid || !Stall;

  always_comb begin
    state_nx  = state;
    kill_nx   = kill;
    pc_inc    = 1'b0;
    load_out  = 1'b0;
    load_skid = 1'b0;
    req_fire  = 1'b0;
    if (Redirect) begin
      // A granted or still-pending request must be drained before fetching the new target.
      case (state)
        ST_WAIT: begin
          if (ImemValid) begin
            kill_nx  = 1'b0;
            state_nx = ST_REQ;
          end else begin
            kill_nx  = 1'b1;
            state_nx = ST_WAIT;
          end
        end
        ST_REQ: begin
          if (ImemGnt) begin
            kill_nx  = 1'b1;
            state_nx = ST_WAIT;
          end else begin
            state_nx = ST_REQ;
          end
        end
        default: state_nx = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_REQ;
        ST_REQ: begin
          if (ImemGnt) begin
            req_fire = 1'b1;
            state_nx = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ImemValid) begin
            state_nx = ST_REQ;
            if (kill) begin
              kill_nx = 1'b0;
            end else if (out_free) begin
              load_out = 1'b1;
              pc_inc   = 1'b1;
            end else begin
              load_skid = 1'b1;
              pc_inc    = 1'b1;
              state_nx  = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!Stall) begin
            load_out = 1'b1;
            state_nx = ST_REQ;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      kill       <= 1'b0;
      req_pc     <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
    end else begin
      state <= state_nx;
      kill  <= kill_nx;
      if (req_fire) begin
        req_pc <= pc;
      end
      if (load_skid) begin
        skid_instr <= ImemData;
        skid_pc    <= req_pc;
      end
      // HOLD is the only state that drains the skid; otherwise the response goes straight out.
      if (Redirect) begin
        out_valid <= 1'b0;
      end else if (load_out) begin
        out_valid <= 1'b1;
        out_instr <= (state == ST_HOLD) ? skid_instr : ImemData;
        out_pc    <= (state == ST_HOLD) ? skid_pc : req_pc;
      end else if (out_valid && !Stall) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign ImemReq    = (state == ST_REQ);
  assign ImemAddr   = pc;
  assign InstrValid = out_valid;
  assign Instr      = out_instr;
  assign InstrPC    = out_pc;
  assign dbg_state  = state;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed timing checks, then randomized traffic against a fetch-stream model.
module tb_pc_fetch;
  import mips_pkg::*;

  localparam logic [31:0] RESET_PC_MAIN = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_WRAP = 32'hFFFF_FFFC;

  // ---------------- clock / reset ----------------
  logic clk, reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         Redirect, Stall, ImemGnt, ImemValid, ImemReq, InstrValid;
  logic [31:0]  NextPC, PCPlus4, ImemAddr, ImemData, Instr, InstrPC;
  fetch_state_e dbg_state;

  pc_fetch #(.RESET_PC(RESET_PC_MAIN)) dut (
    .clk(clk), .reset(reset), .NextPC(NextPC), .Redirect(Redirect), .Stall(Stall),
    .PCPlus4(PCPlus4), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
    .ImemValid(ImemValid), .ImemData(ImemData), .InstrValid(InstrValid), .Instr(Instr),
    .InstrPC(InstrPC), .dbg_state(dbg_state)
  );

  logic         w_req, w_valid, w_ivalid;
  logic [31:0]  w_pc4, w_addr, w_data, w_instr, w_ipc;
  fetch_state_e w_state;

  pc_fetch #(.RESET_PC(RESET_PC_WRAP)) dut_wrap (
    .clk(clk), .reset(reset), .NextPC(32'h0), .Redirect(1'b0), .Stall(1'b0),
    .PCPlus4(w_pc4), .ImemReq(w_req), .ImemAddr(w_addr), .ImemGnt(1'b1),
    .ImemValid(w_valid), .ImemData(w_data), .InstrValid(w_ivalid), .Instr(w_instr),
    .InstrPC(w_ipc), .dbg_state(w_state)
  );

  int total = 0;
  int bad   = 0;
  int delivered = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h0000_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- memory driver ----------------
  logic        gnt_always, spurious;
  int          mem_delay;
  logic        pending, grant_set, valid_set;
  int          cnt;
  logic [31:0] paddr, gaddr;

  initial begin
    ImemGnt = 1'b0; ImemValid = 1'b0; ImemData = '0;
    pending = 1'b0; grant_set = 1'b0; valid_set = 1'b0; cnt = 0; paddr = '0; gaddr = '0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        pending = 1'b0; ImemValid = 1'b0; ImemGnt = 1'b0;
        grant_set = 1'b0; valid_set = 1'b0; ImemData = $urandom;
        continue;
      end
      if (valid_set) pending = 1'b0;
      if (grant_set) begin
        pending = 1'b1;
        cnt     = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        paddr   = gaddr;
      end
      ImemValid = 1'b0;
      ImemData  = $urandom;
      if (pending) begin
        if (cnt == 0) begin
          ImemValid = 1'b1;
          ImemData  = mem_word(paddr);
        end else begin
          cnt--;
        end
      end else if (spurious) begin
        ImemValid = ($urandom_range(0, 9) == 0);
      end
      ImemGnt   = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
      grant_set = ImemReq && ImemGnt;
      gaddr     = ImemAddr;
      valid_set = ImemValid;
    end
  end

  // Wrap instance responder: grant is tied high, answer in the cycle after each request.
  logic w_grant_last;
  logic [31:0] w_log[$];
  initial begin
    w_valid = 1'b0; w_data = '0; w_grant_last = 1'b0;
    forever begin
      @(negedge clk); #2;
      w_valid      = w_grant_last;
      w_data       = $urandom;
      w_grant_last = w_req && !reset;
    end
  end
  initial begin
    forever begin
      @(negedge clk); #4;
      if (!reset && w_req && w_log.size() < 2) w_log.push_back(w_addr);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // The delivered stream must be the sequential stream from the last reset or redirect target.
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        had_hold, had_wait;
  logic [31:0] h_instr, h_pc, h_addr;

  function automatic void refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
  endfunction

  initial begin
    logic [63:0] e;
    exp_pc = RESET_PC_MAIN; had_hold = 1'b0; had_wait = 1'b0;
    h_instr = '0; h_pc = '0; h_addr = '0;
    forever begin
      @(negedge clk); #4;
      if (reset) begin
        exp_q.delete();
        exp_pc = RESET_PC_MAIN;
        refill();
        had_hold = 1'b0;
        had_wait = 1'b0;
        continue;
      end
      if (had_hold) begin
        check("hold_valid", 32'(InstrValid), 32'd1);
        check("hold_instr", Instr, h_instr);
        check("hold_pc", InstrPC, h_pc);
      end
      if (had_wait) begin
        check("addr_stable_req", 32'(ImemReq), 32'd1);
        check("addr_stable", ImemAddr, h_addr);
      end
      if (ImemReq) begin
        check("addr_align", 32'(ImemAddr[1:0]), 32'd0);
        check("single_outstanding", 32'(pending), 32'd0);
      end
      if (InstrValid && !Stall && !Redirect) begin
        if (exp_q.size() == 0) refill();
        e = exp_q.pop_front();
        check("deliver_pc", InstrPC, e[63:32]);
        check("deliver_instr", Instr, e[31:0]);
        delivered++;
        refill();
      end
      if (Redirect) begin
        exp_q.delete();
        exp_pc = NextPC & ~32'h3;
        refill();
      end
      had_hold = InstrValid && Stall && !Redirect;
      h_instr  = Instr;
      h_pc     = InstrPC;
      had_wait = ImemReq && !ImemGnt && !Redirect;
      h_addr   = ImemAddr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input fetch_state_e s, input int max, input string name);
    int n = 0;
    while (dbg_state != s && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(dbg_state), 32'(s));
  endtask

  task automatic wait_req(input int max, input string name);
    int n = 0;
    while (!ImemReq && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(ImemReq), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ivalid"}, 32'(InstrValid), 32'd0);
    check({tag, "_instr"}, Instr, 32'd0);
    check({tag, "_ipc"}, InstrPC, 32'd0);
    check({tag, "_req"}, 32'(ImemReq), 32'd0);
    check({tag, "_addr"}, ImemAddr, RESET_PC_MAIN);
    check({tag, "_pcplus4"}, PCPlus4, RESET_PC_MAIN + 32'd4);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; Redirect = 1'b0; Stall = 1'b0; NextPC = '0;
    gnt_always = 1'b1; mem_delay = 0; spurious = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("wrap_reset_pcplus4", w_pc4, 32'h0000_0000);
    reset = 1'b0;                                   // cycle 0: IDLE
    @(negedge clk);                                 // cycle 1
    check("first_req", 32'(ImemReq), 32'd1);
    check("first_addr", ImemAddr, 32'h0);
    @(negedge clk);                                 // cycle 2
    check("c2_req", 32'(ImemReq), 32'd0);
    check("c2_ivalid", 32'(InstrValid), 32'd0);
    @(negedge clk);                                 // cycle 3
    check("c3_ivalid", 32'(InstrValid), 32'd1);
    check("c3_ipc", InstrPC, 32'h0);
    check("c3_instr", Instr, 32'h2001_0005);
    check("c3_addr", ImemAddr, 32'h4);
    Stall = 1'b1;
    @(negedge clk);                                 // cycle 4: response lands on a stalled output
    check("c4_state", 32'(dbg_state), 32'(ST_WAIT));
    @(negedge clk);                                 // cycle 5
    check("hold_state", 32'(dbg_state), 32'(ST_HOLD));
    check("hold_no_req", 32'(ImemReq), 32'd0);
    check("hold_pcplus4", PCPlus4, 32'hC);
    @(negedge clk);                                 // cycle 6
    check("hold_no_req2", 32'(ImemReq), 32'd0);
    check("hold_instr_kept", Instr, 32'h2001_0005);
    Stall = 1'b0;
    @(negedge clk);                                 // cycle 7
    check("skid_ivalid", 32'(InstrValid), 32'd1);
    check("skid_ipc", InstrPC, 32'h4);
    check("skid_instr", Instr, 32'h0);
    check("after_hold_addr", ImemAddr, 32'h8);
    mem_delay = 2;
    @(negedge clk);                                 // cycle 8: request for 0x8 outstanding
    check("redir_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    Redirect = 1'b1; NextPC = 32'h0000_0040;
    @(negedge clk);
    Redirect = 1'b0;
    check("kill_state", 32'(dbg_state), 32'(ST_WAIT));
    check("kill_no_req", 32'(ImemReq), 32'd0);
    check("kill_ivalid", 32'(InstrValid), 32'd0);
    check("kill_pcplus4", PCPlus4, 32'h44);
    wait_req(10, "redir_req_timeout");
    check("redir_addr", ImemAddr, 32'h40);
    check("redir_ivalid", 32'(InstrValid), 32'd0);
    mem_delay = 0;
    @(negedge clk);                                 // WAIT with response this cycle
    Redirect = 1'b1; NextPC = 32'h0;
    @(negedge clk);
    Redirect = 1'b0;
    check("drop_state", 32'(dbg_state), 32'(ST_REQ));
    check("drop_req", 32'(ImemReq), 32'd1);
    check("drop_addr", ImemAddr, 32'h0);
    check("drop_ivalid", 32'(InstrValid), 32'd0);
    Stall = 1'b1;
    wait_state(ST_HOLD, 10, "reach_hold");
    reset = 1'b1; Redirect = 1'b1; NextPC = 32'h0000_1234;
    @(negedge clk);
    check_reset_outputs("reset_in_hold");
    reset = 1'b0; Redirect = 1'b0; Stall = 1'b0;

    gnt_always = 1'b0; mem_delay = -1; spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      Stall    = ($urandom_range(0, 9) < 4);
      Redirect = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) NextPC = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           NextPC = $urandom;
    end
    Redirect = 1'b0; Stall = 1'b0;
    repeat (5) @(negedge clk);

    check("progress", 32'(delivered >= 100), 32'd1);
    if (w_log.size() == 2) begin
      check("wrap_first_addr", w_log[0], 32'hFFFF_FFFC);
      check("wrap_second_addr", w_log[1], 32'h0000_0000);
    end else begin
      total++;
      bad++;
      $display("FAIL wrap_log: got %0d requests expected 2", w_log.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the MIPS datapath: holds the program counter, issues one instruction-memory request at a time, and delivers fetched instructions with their PC to decode. It consumes the 32-bit next-PC produced by the upstream PC-select mux on a redirect, otherwise steps PC by 4. It exports PC+4 back to that mux.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] forced 0)
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- NextPC  input  32  redirect target from PC-select mux (zero on restart)
- Redirect  input  1  load NextPC into PC this edge, flush in-flight/held work
- Stall  input  1  decode cannot accept the current output instruction
- PCPlus4  output  32  PC + 4, combinational from PC register
- ImemReq  output  1  request valid
- ImemAddr  output  32  request address, equals PC, bits [1:0] = 0
- ImemGnt  input  1  memory accepts request this cycle
- ImemValid  input  1  response data valid
- ImemData  input  32  response instruction
- InstrValid  output  1  Instr/InstrPC valid for decode
- Instr  output  32  fetched instruction
- InstrPC  output  32  address Instr was fetched from

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset: state IDLE, PC = RESET_PC, Kill = 0, ImemReq = 0, InstrValid = 0, Instr = 0, InstrPC = 0, skid buffer empty; PCPlus4 = RESET_PC + 4.
- IDLE: ImemReq = 0; next state REQ unconditionally.
- REQ: ImemReq = 1, ImemAddr = PC; ImemGnt = 1 -> WAIT (record request PC), else stay.
- WAIT: on ImemValid: if Kill, discard data, clear Kill, -> REQ. Else if output register free (InstrValid = 0, or InstrValid = 1 and Stall = 0): load Instr/InstrPC, InstrValid = 1, PC <= PC + 4, -> REQ. Else store in skid buffer, PC <= PC + 4, -> HOLD.
- HOLD: when Stall = 0: skid -> output register, -> REQ.
- Output register: cleared (InstrValid <= 0) when consumed (InstrValid & !Stall) and nothing new loads.
- Redirect (priority over Stall and all state actions): PC <= {NextPC[31:2], 2'b00}; InstrValid <= 0; skid buffer emptied; from WAIT, or REQ with ImemGnt = 1 same cycle: Kill <= 1, -> WAIT; from HOLD/REQ without grant: -> REQ; from IDLE: -> REQ. No PC +4 on a redirect edge.
- Response arriving same cycle as Redirect is discarded.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- reset overrides Redirect and all other inputs.
- At most one outstanding request; ImemValid outside WAIT ignored.

## Timing
- Best case (ImemGnt in REQ, ImemValid next cycle): request at cycle n, InstrValid at n+2; one instruction per 2 cycles.
- First request one cycle after reset deasserts (IDLE -> REQ).
- Redirect at edge n: ImemReq with new address at cycle n+1 (unless killing an outstanding request; then after its response).
- ImemAddr stable while ImemReq = 1 and ImemGnt = 0.
- Instr/InstrPC/InstrValid held stable while Stall = 1.

## Structure
- Shared package mips_pkg: fetch state encoding, PC_STEP = 4, default RESET_PC, 32-bit word typedef.
- Sub-module pc_reg: PC register with sync reset, load (Redirect), increment (+4, wrap) and PCPlus4 output; FSM, Kill flag and output/skid registers stay in pc_fetch.

## Test plan
- Reset, ImemGnt tied 1, ImemValid one cycle after grant, data 32'h2001_0005 -> first ImemAddr 0 at cycle 1, InstrValid with InstrPC 0 at cycle 3, next ImemAddr 4.
- Stall held 3 cycles while response 32'h0000_0000 arrives with output occupied -> HOLD, no new ImemReq, Instr unchanged; after Stall drops, buffered instr appears, PC = prior + 8 sequence intact.
- Redirect with NextPC 32'h0000_0040 in WAIT -> pending response discarded, InstrValid 0, next ImemAddr 32'h40.
- Redirect with NextPC 0 and ImemValid same cycle -> data dropped, next request address 0.
- Wrap: RESET_PC = 32'hFFFF_FFFC -> second request address 32'h0000_0000.
- reset asserted in HOLD with Redirect high -> all outputs to reset values, state IDLE, PC = RESET_PC.
